// File: rtl/pipe_hazard_if.sv
// Pipeline hazard controller signal bundle: stage status in, freeze/stall/flush controls out.
// The pipeline (master) drives the stage status; the controller (slave) drives the controls.
interface pipe_hazard_if;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [3:0] exe_dest;
    logic       mem_wb_en;
    logic [3:0] mem_dest;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic       id_src1_valid;
    logic       branch_taken;
    logic       sram_freeze;
    logic       sram_start;
    logic       hazard_stall;
    logic       flush;

    modport master (
        output mem_r_en, mem_w_en, exe_wb_en, exe_mem_r_en, exe_dest,
               mem_wb_en, mem_dest, id_src1, id_src2, id_two_src,
               id_src1_valid, branch_taken,
        input  sram_freeze, sram_start, hazard_stall, flush
    );

    modport slave (
        input  mem_r_en, mem_w_en, exe_wb_en, exe_mem_r_en, exe_dest,
               mem_wb_en, mem_dest, id_src1, id_src2, id_two_src,
               id_src1_valid, branch_taken,
        output sram_freeze, sram_start, hazard_stall, flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: SRAM access sequencer, RAW hazard detection, branch flush.
// Define PIPE_FWD_EN when a forwarding unit exists: only load-use hazards then stall.
//
// state  | meaning
// IDLE   | no SRAM access; a MEM-stage load/store starts one this cycle
// ACCESS | access in flight; freeze while cnt != 0, release when cnt == 0
module pipe_hazard_ctrl #(
    parameter int unsigned SRAM_WAIT = 6
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.slave  ctrl_if
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SRAM_WAIT - 2);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       req;
    logic       start;
    logic       freeze;
    logic       hz;
    logic       m1_exe, m2_exe;

    assign req = ctrl_if.mem_r_en | ctrl_if.mem_w_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        freeze  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    start   = 1'b1;
                    freeze  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Requests are ignored here: the requester is held in MEM by the freeze.
                if (cnt_q != 4'd0) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m1_exe = ctrl_if.id_src1_valid & (ctrl_if.id_src1 == ctrl_if.exe_dest);
    assign m2_exe = ctrl_if.id_two_src    & (ctrl_if.id_src2 == ctrl_if.exe_dest);

`ifdef PIPE_FWD_EN
    logic unused_hz_inputs;
    assign unused_hz_inputs = ^{ctrl_if.exe_wb_en, ctrl_if.mem_wb_en, ctrl_if.mem_dest};
    assign hz = ctrl_if.exe_mem_r_en & (m1_exe | m2_exe);
`else
    logic m1_mem, m2_mem;
    logic unused_hz_inputs;
    assign unused_hz_inputs = ctrl_if.exe_mem_r_en;
    assign m1_mem = ctrl_if.id_src1_valid & (ctrl_if.id_src1 == ctrl_if.mem_dest);
    assign m2_mem = ctrl_if.id_two_src    & (ctrl_if.id_src2 == ctrl_if.mem_dest);
    assign hz = (ctrl_if.exe_wb_en & (m1_exe | m2_exe))
              | (ctrl_if.mem_wb_en & (m1_mem | m2_mem));
`endif

    // Freeze dominates; a flush dominates a stall; reset silences everything immediately.
    assign ctrl_if.sram_start   = ~rst & start;
    assign ctrl_if.sram_freeze  = ~rst & freeze;
    assign ctrl_if.flush        = ~rst & ctrl_if.branch_taken & ~freeze;
    assign ctrl_if.hazard_stall = ~rst & hz & ~freeze & ~ctrl_if.branch_taken;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: SRAM_WAIT=6 and SRAM_WAIT=2 instances on shared inputs.
// Output vectors are {sram_start, sram_freeze, hazard_stall, flush}.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_if bus();
    pipe_hazard_if bus2();

    assign bus2.mem_r_en      = bus.mem_r_en;
    assign bus2.mem_w_en      = bus.mem_w_en;
    assign bus2.exe_wb_en     = bus.exe_wb_en;
    assign bus2.exe_mem_r_en  = bus.exe_mem_r_en;
    assign bus2.exe_dest      = bus.exe_dest;
    assign bus2.mem_wb_en     = bus.mem_wb_en;
    assign bus2.mem_dest      = bus.mem_dest;
    assign bus2.id_src1       = bus.id_src1;
    assign bus2.id_src2       = bus.id_src2;
    assign bus2.id_two_src    = bus.id_two_src;
    assign bus2.id_src1_valid = bus.id_src1_valid;
    assign bus2.branch_taken  = bus.branch_taken;

    pipe_hazard_ctrl #(.SRAM_WAIT(6)) dut  (.clk(clk), .rst(rst), .ctrl_if(bus));
    pipe_hazard_ctrl #(.SRAM_WAIT(2)) dut2 (.clk(clk), .rst(rst), .ctrl_if(bus2));

    typedef struct {
        logic       exe_wb;
        logic       exe_mrd;
        logic [3:0] exe_dest;
        logic       mem_wb;
        logic [3:0] mem_dest;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       two;
        logic       v1;
        logic       br;
        logic [3:0] exp_nofwd;
        logic [3:0] exp_fwd;
        string      name;
    } hz_vec_t;

    typedef struct {
        logic [3:0] e1;
        logic [3:0] e2;
        string      name;
    } sb_t;

    hz_vec_t tbl [11];
    sb_t     sb [$];
    int      checks = 0;
    int      errors = 0;

    // Wide access: request held 7 cycles, then idle
    logic [3:0] seq_a1 [13] = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1100,
                                4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] seq_a2 [13] = '{4'b1100, 4'b0000, 4'b1100, 4'b0000, 4'b1100, 4'b0000, 4'b1100,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] seq_b1 [7]  = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
    logic [3:0] seq_b2 [7]  = '{4'b1100, 4'b0001, 4'b1100, 4'b0001, 4'b1100, 4'b0001, 4'b0000};
    logic [3:0] seq_c1 [4]  = '{4'b1100, 4'b0100, 4'b0100, 4'b0100};
    logic [3:0] seq_c2 [4]  = '{4'b1100, 4'b0000, 4'b1100, 4'b0000};
    logic [3:0] seq_d1 [7]  = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] seq_d2 [7]  = '{4'b1100, 4'b0000, 4'b1100, 4'b0000, 4'b1100, 4'b0000, 4'b0000};

    task automatic set_in(input logic r, input logic w, input logic exe_wb, input logic exe_mrd,
                          input logic [3:0] exe_dest, input logic mem_wb, input logic [3:0] mem_dest,
                          input logic [3:0] src1, input logic [3:0] src2, input logic two,
                          input logic v1, input logic br);
        bus.mem_r_en      = r;
        bus.mem_w_en      = w;
        bus.exe_wb_en     = exe_wb;
        bus.exe_mem_r_en  = exe_mrd;
        bus.exe_dest      = exe_dest;
        bus.mem_wb_en     = mem_wb;
        bus.mem_dest      = mem_dest;
        bus.id_src1       = src1;
        bus.id_src2       = src2;
        bus.id_two_src    = two;
        bus.id_src1_valid = v1;
        bus.branch_taken  = br;
    endtask

    task automatic expect_out(input logic [3:0] e1, input logic [3:0] e2, input string nm);
        sb_t s;
        s.e1 = e1;
        s.e2 = e2;
        s.name = nm;
        sb.push_back(s);
    endtask

    task automatic check_out();
        sb_t s;
        logic [3:0] got1, got2;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got nothing queued, required one expectation");
            return;
        end
        s = sb.pop_front();
        got1 = {bus.sram_start, bus.sram_freeze, bus.hazard_stall, bus.flush};
        got2 = {bus2.sram_start, bus2.sram_freeze, bus2.hazard_stall, bus2.flush};
        checks++;
        if (got1 !== s.e1) begin
            errors++;
            $display("FAIL %s (wait6): got %b required %b", s.name, got1, s.e1);
        end
        checks++;
        if (got2 !== s.e2) begin
            errors++;
            $display("FAIL %s (wait2): got %b required %b", s.name, got2, s.e2);
        end
    endtask

    task automatic mem_step(input logic rs, input logic r, input logic w, input logic br,
                            input logic [3:0] e1, input logic [3:0] e2, input string nm);
        @(negedge clk);
        rst = rs;
        set_in(r, w, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, br);
        expect_out(e1, e2, nm);
        #2;
        check_out();
    endtask

    initial begin
        //            exe_wb exe_mrd dest  mem_wb mdest src1  src2  two   v1    br    nofwd    fwd
        tbl[0]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, "mem_dep_src1"};
        tbl[1]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "mem_dep_src1_invalid"};
        tbl[2]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, "load_use_src2"};
        tbl[3]  = '{1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, "alu_dep_src2"};
        tbl[4]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd4, 4'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, "src2_unused"};
        tbl[5]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001, "flush_beats_stall"};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001, "branch_only"};
        tbl[7]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "no_sources"};
        tbl[8]  = '{1'b0, 1'b0, 4'd7, 1'b1, 4'd2, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, "no_writer_match"};
        tbl[9]  = '{1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, "load_use_r0"};
        tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, "mem_dep_src2"};

        set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1);
        #3;
        expect_out(4'b0000, 4'b0000, "reset_outputs");
        check_out();
        mem_step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, "reset_hold_req");
        mem_step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "after_reset_idle");

        for (int i = 0; i < 11; i++) begin
            logic [3:0] e;
`ifdef PIPE_FWD_EN
            e = tbl[i].exp_fwd;
`else
            e = tbl[i].exp_nofwd;
`endif
            @(negedge clk);
            set_in(1'b0, 1'b0, tbl[i].exe_wb, tbl[i].exe_mrd, tbl[i].exe_dest, tbl[i].mem_wb,
                   tbl[i].mem_dest, tbl[i].src1, tbl[i].src2, tbl[i].two, tbl[i].v1, tbl[i].br);
            expect_out(e, e, tbl[i].name);
            #2;
            check_out();
        end

        for (int i = 0; i < 13; i++)
            mem_step(1'b0, 1'b0, (i < 7), 1'b0, seq_a1[i], seq_a2[i], $sformatf("store_seq_c%0d", i));

        for (int i = 0; i < 7; i++)
            mem_step(1'b0, (i < 6), 1'b0, (i < 6), seq_b1[i], seq_b2[i], $sformatf("branch_freeze_c%0d", i));

        for (int i = 0; i < 4; i++)
            mem_step(1'b0, 1'b1, 1'b0, 1'b0, seq_c1[i], seq_c2[i], $sformatf("pre_reset_c%0d", i));
        rst = 1'b1;
        expect_out(4'b0000, 4'b0000, "mid_access_reset");
        #1;
        check_out();
        mem_step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, "reset_across_edge");
        for (int i = 0; i < 7; i++)
            mem_step(1'b0, (i < 5), 1'b0, 1'b0, seq_d1[i], seq_d2[i], $sformatf("post_reset_c%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
